// File: rtl/ofs_fim_eth_axis_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : ofs_fim_eth_axis_tx_pkt_gen
// Description : AFU-side Ethernet TX frame generator. Drives the 64-bit TX
//               AXI-S channel with frames built from runtime configuration:
//               a DA/SA/EtherType header followed by an incrementing-byte
//               payload. Supports fixed-count or continuous runs, a
//               programmable inter-packet gap and a graceful stop.
// Ports       : clk, rst_n (sync, active-low)
//               start / stop             run control pulses
//               cfg_*                    frame config, latched at start
//               tx_t{valid,ready,data,keep,last,user}  AXI-S master
//               busy, done, pkts_sent    run status
//               bytes_sent               (only with OFS_FIM_ETH_PKTGEN_STATS_EN)
// Options     : `define OFS_FIM_ETH_PKTGEN_STATS_EN adds the saturating
//               bytes_sent counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ofs_fim_eth_axis_tx_pkt_gen #(
  parameter int MIN_PKT_LEN = 64,
  parameter int MAX_PKT_LEN = 9600,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [13:0]          cfg_pkt_len,
  input  logic [CNT_WIDTH-1:0] cfg_pkt_cnt,
  input  logic [7:0]           cfg_ipg,
  input  logic [47:0]          cfg_dst_mac,
  input  logic [47:0]          cfg_src_mac,
  input  logic [15:0]          cfg_ethertype,
  output logic                 tx_tvalid,
  input  logic                 tx_tready,
  output logic [63:0]          tx_tdata,
  output logic [7:0]           tx_tkeep,
  output logic                 tx_tlast,
  output logic                 tx_tuser,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] pkts_sent
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
  ,
  output logic [47:0]          bytes_sent
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Byte idx (0 = first on the wire) of a MAC address held MSB-first.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      default: b = mac[7:0];
    endcase
    return b;
  endfunction

  // Full 8-byte content of a beat; bytes past the frame end are don't-care
  // (masked by tkeep) and simply continue the payload sequence.
  function automatic logic [63:0] beat_data(input logic [10:0] beat, input logic [7:0] seed,
                                            input logic [47:0] da, input logic [47:0] sa,
                                            input logic [15:0] et);
    logic [63:0] d;
    logic [13:0] k;
    d = '0;
    for (int n = 0; n < 8; n++) begin
      k = {beat, 3'b000} + 14'(n);
      if (k < 14'd6)        d[n*8 +: 8] = mac_byte(da, k[2:0]);
      else if (k < 14'd12)  d[n*8 +: 8] = mac_byte(sa, 3'(k - 14'd6));
      else if (k == 14'd12) d[n*8 +: 8] = et[15:8];
      else if (k == 14'd13) d[n*8 +: 8] = et[7:0];
      else                  d[n*8 +: 8] = seed + k[7:0] - 8'd14;
    end
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(input logic [10:0] beat, input logic [10:0] last_beat,
                                           input logic [2:0] rem);
    logic [7:0] kp;
    if (beat == last_beat && rem != 3'd0) kp = (8'd1 << rem) - 8'd1;
    else                                  kp = 8'hFF;
    return kp;
  endfunction

  state_t               state_q, state_d;
  logic [2:0]           rem_q, rem_d;            // len % 8 of the latched length
  logic [10:0]          last_beat_q, last_beat_d;
  logic [10:0]          beat_q, beat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           ipg_q, ipg_d;
  logic [7:0]           gap_q, gap_d;
  logic [47:0]          dmac_q, dmac_d;
  logic [47:0]          smac_q, smac_d;
  logic [15:0]          etype_q, etype_d;
  logic [7:0]           seed_q, seed_d;
  logic                 stop_pend_q, stop_pend_d;
  logic [CNT_WIDTH-1:0] pkts_sent_q, pkts_sent_d;
  logic                 tvalid_q, tvalid_d;
  logic [63:0]          tdata_q, tdata_d;
  logic [7:0]           tkeep_q, tkeep_d;
  logic                 tlast_q, tlast_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 hs;
  logic                 load_beat;
  logic [13:0]          len_clamp;
  logic [13:0]          beats_clamp;
  logic [10:0]          last_beat_clamp;

  assign hs = tvalid_q & tx_tready;

  always_comb begin
    if (cfg_pkt_len < 14'(MIN_PKT_LEN))      len_clamp = 14'(MIN_PKT_LEN);
    else if (cfg_pkt_len > 14'(MAX_PKT_LEN)) len_clamp = 14'(MAX_PKT_LEN);
    else                                     len_clamp = cfg_pkt_len;
    beats_clamp     = (len_clamp + 14'd7) >> 3;
    last_beat_clamp = 11'(beats_clamp - 14'd1);
  end

`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
  logic [47:0] bytes_q, bytes_d;
  logic [3:0]  keep_cnt;
  logic [48:0] bytes_sum;

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < 8; i++) keep_cnt = keep_cnt + {3'b000, tkeep_q[i]};
    bytes_sum = {1'b0, bytes_q} + {45'd0, keep_cnt};
  end
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    last_beat_d = last_beat_q;
    beat_d      = beat_q;
    cnt_d       = cnt_q;
    ipg_d       = ipg_q;
    gap_d       = gap_q;
    dmac_d      = dmac_q;
    smac_d      = smac_q;
    etype_d     = etype_q;
    seed_d      = seed_q;
    stop_pend_d = stop_pend_q;
    pkts_sent_d = pkts_sent_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_beat   = 1'b0;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
    bytes_d     = bytes_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // stop is deliberately not sampled here: start wins when both pulse.
        if (start) begin
          rem_d       = len_clamp[2:0];
          last_beat_d = last_beat_clamp;
          cnt_d       = cfg_pkt_cnt;
          ipg_d       = cfg_ipg;
          dmac_d      = cfg_dst_mac;
          smac_d      = cfg_src_mac;
          etype_d     = cfg_ethertype;
          pkts_sent_d = '0;
          stop_pend_d = 1'b0;
          beat_d      = '0;
          seed_d      = '0;
          busy_d      = 1'b1;
          load_beat   = 1'b1;
          state_d     = ST_SEND;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
          bytes_d     = '0;
`endif
        end
      end

      ST_SEND: begin
        stop_pend_d = stop_pend_q | stop;
        if (hs) begin
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
          bytes_d = bytes_sum[48] ? '1 : bytes_sum[47:0];
`endif
          if (tlast_q) begin
            pkts_sent_d = pkts_sent_q + CNT_WIDTH'(1);
            // A count of 0 never matches, so continuous runs end only on stop.
            if (stop_pend_d || (cnt_q != '0 && pkts_sent_d == cnt_q)) begin
              tvalid_d = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = ST_FIN;
            end else if (ipg_q != 8'd0) begin
              tvalid_d = 1'b0;
              gap_d    = ipg_q;
              state_d  = ST_GAP;
            end else begin
              beat_d    = '0;
              seed_d    = pkts_sent_d[7:0];
              load_beat = 1'b1;
            end
          end else begin
            beat_d    = beat_q + 11'd1;
            load_beat = 1'b1;
          end
        end
      end

      ST_GAP: begin
        stop_pend_d = stop_pend_q | stop;
        if (stop_pend_d) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_FIN;
        end else if (gap_q == 8'd1) begin
          beat_d    = '0;
          seed_d    = pkts_sent_q[7:0];
          load_beat = 1'b1;
          state_d   = ST_SEND;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every new beat is built from the next-state config so the first beat
    // after start uses the freshly latched values.
    if (load_beat) begin
      tvalid_d = 1'b1;
      tdata_d  = beat_data(beat_d, seed_d, dmac_d, smac_d, etype_d);
      tkeep_d  = beat_keep(beat_d, last_beat_d, rem_d);
      tlast_d  = (beat_d == last_beat_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      last_beat_q <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      ipg_q       <= '0;
      gap_q       <= '0;
      dmac_q      <= '0;
      smac_q      <= '0;
      etype_q     <= '0;
      seed_q      <= '0;
      stop_pend_q <= 1'b0;
      pkts_sent_q <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
      bytes_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      last_beat_q <= last_beat_d;
      beat_q      <= beat_d;
      cnt_q       <= cnt_d;
      ipg_q       <= ipg_d;
      gap_q       <= gap_d;
      dmac_q      <= dmac_d;
      smac_q      <= smac_d;
      etype_q     <= etype_d;
      seed_q      <= seed_d;
      stop_pend_q <= stop_pend_d;
      pkts_sent_q <= pkts_sent_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
      bytes_q     <= bytes_d;
`endif
    end
  end

  assign tx_tvalid = tvalid_q;
  assign tx_tdata  = tdata_q;
  assign tx_tkeep  = tkeep_q;
  assign tx_tlast  = tlast_q;
  assign tx_tuser  = 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pkts_sent = pkts_sent_q;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
  assign bytes_sent = bytes_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ofs_fim_eth_axis_tx_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ofs_fim_eth_axis_tx_pkt_gen
// Description : Directed self-checking bench for the TX frame generator.
//               Expected beats are queued when a run is started and popped
//               on every observed AXI-S handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ofs_fim_eth_axis_tx_pkt_gen;

  localparam int CW      = 32;
  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 9600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [13:0]   cfg_pkt_len = '0;
  logic [CW-1:0] cfg_pkt_cnt = '0;
  logic [7:0]    cfg_ipg = '0;
  logic [47:0]   cfg_dst_mac = '0;
  logic [47:0]   cfg_src_mac = '0;
  logic [15:0]   cfg_ethertype = '0;
  logic          tx_tvalid;
  logic          tx_tready = 1'b1;
  logic [63:0]   tx_tdata;
  logic [7:0]    tx_tkeep;
  logic          tx_tlast;
  logic          tx_tuser;
  logic          busy;
  logic          done;
  logic [CW-1:0] pkts_sent;
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
  logic [47:0]   bytes_sent;
`endif

  ofs_fim_eth_axis_tx_pkt_gen #(
    .MIN_PKT_LEN(MIN_LEN),
    .MAX_PKT_LEN(MAX_LEN),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_pkt_cnt  (cfg_pkt_cnt),
    .cfg_ipg      (cfg_ipg),
    .cfg_dst_mac  (cfg_dst_mac),
    .cfg_src_mac  (cfg_src_mac),
    .cfg_ethertype(cfg_ethertype),
    .tx_tvalid    (tx_tvalid),
    .tx_tready    (tx_tready),
    .tx_tdata     (tx_tdata),
    .tx_tkeep     (tx_tkeep),
    .tx_tlast     (tx_tlast),
    .tx_tuser     (tx_tuser),
    .busy         (busy),
    .done         (done),
    .pkts_sent    (pkts_sent)
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
    ,
    .bytes_sent   (bytes_sent)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t sb[$];

  task automatic push_frame(input int len_req, input logic [7:0] seed, input logic [47:0] da,
                            input logic [47:0] sa, input logic [15:0] et);
    int          len;
    int          nb;
    logic [7:0]  fb[$];
    logic [47:0] t48;
    logic [15:0] t16;
    beat_t       b;
    len = (len_req < MIN_LEN) ? MIN_LEN : ((len_req > MAX_LEN) ? MAX_LEN : len_req);
    for (int i = 0; i < len; i++) begin
      if (i < 6) begin
        t48 = da >> (8 * (5 - i));
        fb.push_back(t48[7:0]);
      end else if (i < 12) begin
        t48 = sa >> (8 * (11 - i));
        fb.push_back(t48[7:0]);
      end else if (i < 14) begin
        t16 = et >> (8 * (13 - i));
        fb.push_back(t16[7:0]);
      end else begin
        fb.push_back(8'(seed + 8'(i - 14)));
      end
    end
    nb = (len + 7) / 8;
    for (int bt = 0; bt < nb; bt++) begin
      b.data = '0;
      b.keep = '0;
      for (int n = 0; n < 8; n++) begin
        if (bt * 8 + n < len) begin
          b.data[n*8 +: 8] = fb[bt*8 + n];
          b.keep[n]        = 1'b1;
        end
      end
      b.last = (bt == nb - 1);
      sb.push_back(b);
    end
  endtask

  task automatic push_run(input int len_req, input int frames, input logic [47:0] da,
                          input logic [47:0] sa, input logic [15:0] et);
    for (int f = 0; f < frames; f++) push_frame(len_req, 8'(f), da, sa, et);
  endtask

  // ---------------- tready driver ----------------
  bit rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    tx_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          prev_stall = 1'b0;
  logic [63:0] hold_d;
  logic [7:0]  hold_k;
  logic        hold_l;
  bit          after_tlast = 1'b0;
  int unsigned tlast_cyc = 0;
  int          gaps[$];
  beat_t       mon_e;
  logic [63:0] mon_mask;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      after_tlast = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_tvalid", tx_tvalid, 1);
        check("hold_tdata", tx_tdata, hold_d);
        check("hold_tkeep", tx_tkeep, hold_k);
        check("hold_tlast", tx_tlast, hold_l);
      end
      if (tx_tvalid && after_tlast) begin
        gaps.push_back(int'(cyc - tlast_cyc) - 1);
        after_tlast = 1'b0;
      end
      if (done) after_tlast = 1'b0;
      prev_stall = tx_tvalid && !tx_tready;
      hold_d = tx_tdata;
      hold_k = tx_tkeep;
      hold_l = tx_tlast;
      if (tx_tvalid && tx_tready) begin
        check("sb_has_beat", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          mon_mask = '0;
          for (int n = 0; n < 8; n++) if (mon_e.keep[n]) mon_mask[n*8 +: 8] = 8'hFF;
          check("beat_tkeep", tx_tkeep, mon_e.keep);
          check("beat_tlast", tx_tlast, mon_e.last);
          check("beat_tdata", tx_tdata & mon_mask, mon_e.data);
          check("beat_tuser", tx_tuser, 0);
        end
        if (tx_tlast) begin
          after_tlast = 1'b1;
          tlast_cyc   = cyc;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  int unsigned done_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int len, input int cnt, input int ipg, input logic [47:0] da,
                         input logic [47:0] sa, input logic [15:0] et);
    cfg_pkt_len   = 14'(len);
    cfg_pkt_cnt   = CW'(cnt);
    cfg_ipg       = 8'(ipg);
    cfg_dst_mac   = da;
    cfg_src_mac   = sa;
    cfg_ethertype = et;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done === 1'b1) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    check(tag, seen, 1);
    check({tag, "_busy_low"}, busy, 0);
    check({tag, "_after_tlast"}, done_cyc, tlast_cyc + 1);
    tick();
    check({tag, "_one_cycle"}, done, 0);
  endtask

  task automatic wait_pkts(input int n, input int budget, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (pkts_sent == CW'(n) && tx_tvalid) seen = 1'b1;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [47:0] da;
    logic [47:0] sa;
    logic [15:0] et;
    bit          quiet;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_tvalid", tx_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pkts", pkts_sent, 0);
    check("rst_tkeep", tx_tkeep, 0);
    check("rst_tlast", tx_tlast, 0);
    check("rst_tuser", tx_tuser, 0);
    rst_n = 1'b1;
    tick();

    // 1: single 64-byte frame, no backpressure
    da = 48'h0011_2233_4455;
    sa = 48'hA0B1_C2D3_E4F5;
    et = 16'h88B5;
    set_cfg(64, 1, 0, da, sa, et);
    push_run(64, 1, da, sa, et);
    pulse_start();
    check("t1_busy_rise", busy, 1);
    check("t1_tvalid_rise", tx_tvalid, 1);
    wait_done(100, "t1_done");
    check("t1_pkts", pkts_sent, 1);
    check("t1_sb_empty", sb.size(), 0);

    // 2: 65-byte frames with IPG 4; start+stop together (stop ignored)
    gaps.delete();
    set_cfg(65, 3, 4, da, sa, et);
    push_run(65, 3, da, sa, et);
    stop = 1'b1;
    pulse_start();
    stop = 1'b0;
    wait_done(200, "t2_done");
    check("t2_pkts", pkts_sent, 3);
    check("t2_sb_empty", sb.size(), 0);
    check("t2_gap_count", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check("t2_gap0", gaps[0], 4);
      check("t2_gap1", gaps[1], 4);
    end
    quiet = 1'b1;
    repeat (10) begin
      tick();
      if (tx_tvalid !== 1'b0) quiet = 1'b0;
    end
    check("t2_no_tail_traffic", quiet, 1);

    // 3: length clamping at both ends
    set_cfg(20, 1, 0, da, sa, et);
    push_run(20, 1, da, sa, et);
    pulse_start();
    wait_done(100, "t3a_done");
    check("t3a_sb_empty", sb.size(), 0);
    set_cfg(12000, 1, 0, da, sa, et);
    push_run(12000, 1, da, sa, et);
    pulse_start();
    wait_done(1500, "t3b_done");
    check("t3b_sb_empty", sb.size(), 0);
    check("t3b_pkts", pkts_sent, 1);

    // 4: random backpressure, config changed after start
    da = {16'($urandom), 32'($urandom)};
    sa = {16'($urandom), 32'($urandom)};
    et = 16'($urandom);
    set_cfg(100, 10, 1, da, sa, et);
    push_run(100, 10, da, sa, et);
    rand_ready = 1'b1;
    pulse_start();
    set_cfg(70, 2, 9, ~da, ~sa, ~et);
    wait_done(3000, "t4_done");
    rand_ready = 1'b0;
    check("t4_pkts", pkts_sent, 10);
    check("t4_sb_empty", sb.size(), 0);

    // 5: continuous mode, start while busy ignored, stop mid frame 5
    set_cfg(64, 0, 2, da, sa, et);
    push_run(64, 5, da, sa, et);
    pulse_start();
    wait_pkts(2, 200, "t5_reach2");
    cfg_pkt_len = 14'd100;
    pulse_start();
    check("t5_busy_kept", busy, 1);
    check("t5_pkts_not_cleared", pkts_sent, 2);
    wait_pkts(4, 200, "t5_reach4");
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(100, "t5_done");
    check("t5_pkts", pkts_sent, 5);
    check("t5_sb_empty", sb.size(), 0);

    // 6: reset mid-frame, then a fresh run
    set_cfg(64, 2, 0, da, sa, et);
    push_run(64, 2, da, sa, et);
    pulse_start();
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    check("t6_rst_tvalid", tx_tvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_pkts", pkts_sent, 0);
    tick();
    rst_n = 1'b1;
    sb.delete();
    gaps.delete();
    tick();
    set_cfg(65, 3, 0, da, sa, et);
    push_run(65, 3, da, sa, et);
    pulse_start();
    wait_done(200, "t6_done");
    check("t6_pkts", pkts_sent, 3);
    check("t6_sb_empty", sb.size(), 0);
    check("t6_b2b_gaps", gaps.size(), 2);
    if (gaps.size() == 2) check("t6_gap0", gaps[0], 0);
`ifdef OFS_FIM_ETH_PKTGEN_STATS_EN
    check("t6_bytes_sent", bytes_sent, 195);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
